// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: MIPS opcodes, register types,
// the FIFO entry layout and the per-port forwarding result.
package writeback_stage_pkg;

  typedef logic [4:0]  RegAddr;
  typedef logic [31:0] Register;
  typedef logic        Signal;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    BEQ   = 6'h04,
    ADDI  = 6'h08,
    LW    = 6'h23,
    SW    = 6'h2b
  } OpCode;

  typedef struct packed {
    OpCode   opcode;
    RegAddr  dest;
    Register result;
    Signal   has_write;
    Signal   data_ok;
  } WbEntry;

  typedef struct packed {
    Signal   hazard;
    Register fwd;
  } FwdResult;

  // Builds the entry stored at push; only a load waits for data after push.
  function automatic WbEntry make_entry(logic [5:0] opcode, RegAddr dest, Register result);
    WbEntry e;
    e.opcode    = OpCode'(opcode);
    e.dest      = dest;
    e.result    = result;
    e.has_write = (opcode == RTYPE || opcode == ADDI || opcode == LW) && (dest != '0);
    e.data_ok   = (opcode != LW);
    return e;
  endfunction

endpackage

// File: rtl/writeback_stage_wb_fifo.sv
// wb_fifo: circular DEPTH-entry buffer of WbEntry. Entries are exposed in age
// order (index 0 = head) so the hazard logic can find the youngest match.
module wb_fifo
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  WbEntry                 push_entry,
  input  logic                   pop,
  input  logic                   head_update,
  input  Register                head_result,
  output WbEntry [DEPTH-1:0]     entries,
  output logic   [DEPTH-1:0]     entry_valid,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);

  WbEntry          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + 1'b1;
      end
      // Load data lands in the head entry; the caller never pushes while full,
      // so tail cannot alias head here.
      if (head_update) begin
        mem[head].result  <= head_result;
        mem[head].data_ok <= 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_comb begin
    entries     = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i]     = mem[head + PW'(i)];
      entry_valid[i] = (PW+1)'(i) < count;
    end
  end

  assign full = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: in-order result FIFO draining onto the register-file write
// port, with RAW hazard reporting. Define WB_BYPASS_EN to enable forwarding.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic [4:0]  rs_q,
  input  logic [4:0]  rt_q,
  output logic        rs_hazard,
  output logic        rt_hazard,
  output logic [31:0] rs_fwd,
  output logic [31:0] rt_fwd,
  output logic [31:0] retire_count
);

  WbEntry [DEPTH-1:0] entries;
  logic   [DEPTH-1:0] entry_valid;
  WbEntry             head;
  WbEntry             new_entry;
  logic               full;
  logic               push;
  logic               pop;
  logic               load_now;
  FwdResult           rs_res;
  FwdResult           rt_res;

  // Handshake: a result transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on FIFO occupancy, never on in_valid or on a same-cycle pop.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign new_entry = make_entry(in_opcode, in_dest, in_result);

  assign head     = entries[0];
  assign load_now = entry_valid[0] && !head.data_ok && (head.opcode == LW) && mem_rvalid;
  assign pop      = entry_valid[0] && (head.data_ok || load_now);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (new_entry),
    .pop         (pop),
    .head_update (load_now),
    .head_result (mem_rdata),
    .entries     (entries),
    .entry_valid (entry_valid),
    .full        (full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      retire_count <= '0;
    end else if (pop) begin
      wr_en        <= head.has_write;
      wr_addr      <= head.dest;
      wr_data      <= load_now ? mem_rdata : head.result;
      retire_count <= retire_count + 32'd1;
    end else begin
      wr_en <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest (output register first) so the last match wins.
  function automatic FwdResult lookup(RegAddr q, WbEntry [DEPTH-1:0] ents,
                                      logic [DEPTH-1:0] vld, logic out_en,
                                      RegAddr out_addr, Register out_data);
    FwdResult r;
    logic     found;
    logic     ok;
    Register  val;
    found = out_en && (out_addr == q);
    ok    = 1'b1;
    val   = out_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && ents[i].has_write && ents[i].dest == q) begin
        found = 1'b1;
        ok    = ents[i].data_ok;
        val   = ents[i].result;
      end
    end
    if (q == '0) found = 1'b0;
    r.hazard = found && !ok;
    r.fwd    = found ? val : '0;
    return r;
  endfunction

  assign rs_res = lookup(rs_q, entries, entry_valid, wr_en, wr_addr, wr_data);
  assign rt_res = lookup(rt_q, entries, entry_valid, wr_en, wr_addr, wr_data);
`else
  function automatic FwdResult lookup(RegAddr q, WbEntry [DEPTH-1:0] ents,
                                      logic [DEPTH-1:0] vld, logic out_en,
                                      RegAddr out_addr);
    FwdResult r;
    logic     found;
    found = out_en && (out_addr == q);
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && ents[i].has_write && ents[i].dest == q) found = 1'b1;
    r.hazard = found && (q != '0);
    r.fwd    = '0;
    return r;
  endfunction

  assign rs_res = lookup(rs_q, entries, entry_valid, wr_en, wr_addr);
  assign rt_res = lookup(rt_q, entries, entry_valid, wr_en, wr_addr);
`endif

  // Fields of younger entries only matter to some builds of the hazard logic.
  logic unused_entry_bits;
  assign unused_entry_bits = ^entries;

  assign rs_hazard = rs_res.hazard;
  assign rt_hazard = rt_res.hazard;
  assign rs_fwd    = rs_res.fwd;
  assign rt_fwd    = rt_res.fwd;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: queue-level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_dest;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic        rs_hazard;
  logic        rt_hazard;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;
  logic [31:0] retire_count;

  writeback_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_result(in_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_q(rs_q), .rt_q(rt_q), .rs_hazard(rs_hazard), .rt_hazard(rt_hazard),
    .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .retire_count(retire_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] result;
    bit          has_write;
    bit          data_ok;
  } m_ent_t;

  m_ent_t      m_q[$];
  logic [36:0] exp_q[$];
  bit          m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_retire;
  bit          started = 0;
  logic        bypass_build;

  initial begin
`ifdef WB_BYPASS_EN
    bypass_build = 1'b1;
`else
    bypass_build = 1'b0;
`endif
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest pending writer of q decides: without forwarding any writer is a
  // hazard; with forwarding only a writer still waiting for load data is.
  function automatic logic [32:0] model_hz(logic [4:0] q);
    bit          found = 0;
    bit          ok = 0;
    logic [31:0] v = '0;
    if (q == 5'd0) return 33'd0;
    if (m_wr_en && m_wr_addr == q) begin
      found = 1; ok = 1; v = m_wr_data;
    end
    foreach (m_q[i]) begin
      if (m_q[i].has_write && m_q[i].dest == q) begin
        found = 1; ok = m_q[i].data_ok; v = m_q[i].result;
      end
    end
    if (bypass_build) return {found && !ok, found ? v : 32'd0};
    return {found, 32'd0};
  endfunction

  // ---------------- model + compare process ----------------
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_q.delete();
        exp_q.delete();
        m_wr_en   = 0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_retire  = '0;
        started   = 1;
      end else if (started) begin
        bit          can_take;
        m_ent_t      e;
        can_take = m_q.size() < DEPTH;
        m_wr_en  = 0;
        if (m_q.size() > 0 && (m_q[0].data_ok || mem_rvalid)) begin
          logic [31:0] d;
          d = m_q[0].data_ok ? m_q[0].result : mem_rdata;
          m_wr_en   = m_q[0].has_write;
          m_wr_addr = m_q[0].dest;
          m_wr_data = d;
          m_retire  = m_retire + 32'd1;
          if (m_q[0].has_write) exp_q.push_back({m_q[0].dest, d});
          void'(m_q.pop_front());
        end
        if (in_valid && can_take) begin
          e.dest      = in_dest;
          e.result    = in_result;
          e.has_write = (in_opcode == RTYPE || in_opcode == ADDI || in_opcode == LW) && in_dest != 0;
          e.data_ok   = (in_opcode != LW);
          m_q.push_back(e);
        end
      end
      #1;
      if (started) begin
        logic [32:0] hz_rs;
        logic [32:0] hz_rt;
        hz_rs = model_hz(rs_q);
        hz_rt = model_hz(rt_q);
        chk("in_ready", in_ready, m_q.size() < DEPTH);
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_addr", wr_addr, m_wr_addr);
        chk("wr_data", wr_data, m_wr_data);
        chk("retire_count", retire_count, m_retire);
        chk("rs_hazard", rs_hazard, hz_rs[32]);
        chk("rt_hazard", rt_hazard, hz_rt[32]);
        if (!hz_rs[32]) chk("rs_fwd", rs_fwd, hz_rs[31:0]);
        if (!hz_rt[32]) chk("rt_fwd", rt_fwd, hz_rt[31:0]);
        if (wr_en === 1'b1) begin
          if (exp_q.size() == 0) chk("write_order_unexpected", {27'd0, wr_addr, wr_data}, 64'd0);
          else chk("write_order", {27'd0, wr_addr, wr_data}, {27'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic offer(logic [5:0] op, logic [4:0] dest, logic [31:0] res);
    in_valid  = 1'b1;
    in_opcode = op;
    in_dest   = dest;
    in_result = res;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic chk_write(string name, logic [4:0] a, logic [31:0] d);
    chk({name, "_wr_en"}, wr_en, 1'b1);
    chk({name, "_wr_addr"}, wr_addr, a);
    chk({name, "_wr_data"}, wr_data, d);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [5:0] ops [6];
    ops = '{RTYPE, ADDI, BEQ, LW, SW, J};
    reset = 1'b0; in_valid = 1'b0; in_opcode = '0; in_dest = '0; in_result = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; rs_q = '0; rt_q = '0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_wr_en", wr_en, 1'b0);
    chk("reset_wr_addr", wr_addr, 5'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_retire", retire_count, 32'd0);

    // RTYPE dest 5: write two edges after being offered
    offer(RTYPE, 5'd5, 32'h1234);
    next_cycle();
    idle_in();
    chk("t1_no_early_write", wr_en, 1'b0);
    next_cycle();
    chk_write("t1", 5'd5, 32'h1234);
    chk("t1_retire", retire_count, 32'd1);
    next_cycle();
    chk("t1_strobe_drops", wr_en, 1'b0);
    chk("t1_addr_holds", wr_addr, 5'd5);

    // ADDI to $0 retires silently; rs_q = 0 never flags
    offer(ADDI, 5'd0, 32'h55);
    next_cycle();
    idle_in();
    chk("t2_rs0_hazard", rs_hazard, 1'b0);
    next_cycle();
    chk("t2_wr_en", wr_en, 1'b0);
    chk("t2_retire", retire_count, 32'd2);

    // LW 8 then ADDI 9; load data arrives later, retire stays in order
    offer(LW, 5'd8, 32'h100);
    next_cycle();
    offer(ADDI, 5'd9, 32'h99);
    next_cycle();
    idle_in();
    rs_q = 5'd8; rt_q = 5'd9;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("t3_wait_wr_en", wr_en, 1'b0);
    end
    chk("t3_wait_retire", retire_count, 32'd2);
    chk("t3_lw_hazard", rs_hazard, 1'b1);
    chk("t3_addi_hazard", rt_hazard, !bypass_build);
    if (bypass_build) chk("t3_addi_fwd", rt_fwd, 32'h99);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    next_cycle();
    mem_rvalid = 1'b0;
    rs_q = '0; rt_q = '0;
    chk_write("t3_lw", 5'd8, 32'hCAFE);
    chk("t3_retire_lw", retire_count, 32'd3);
    next_cycle();
    chk_write("t3_addi", 5'd9, 32'h99);
    chk("t3_retire_addi", retire_count, 32'd4);

    // Full FIFO behind a waiting LW refuses a push even on the popping edge
    offer(LW, 5'd10, 32'h10);
    next_cycle();
    offer(ADDI, 5'd11, 32'h11);
    next_cycle();
    offer(ADDI, 5'd12, 32'h77);
    chk("t4_full", in_ready, 1'b0);
    next_cycle();
    next_cycle();
    chk("t4_still_full", in_ready, 1'b0);
    chk("t4_no_retire", retire_count, 32'd4);
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF;
    next_cycle();
    mem_rvalid = 1'b0;
    chk_write("t4_lw", 5'd10, 32'hBEEF);
    chk("t4_ready_after_pop", in_ready, 1'b1);
    next_cycle();
    idle_in();
    chk_write("t4_addi11", 5'd11, 32'h11);
    next_cycle();
    chk_write("t4_addi12", 5'd12, 32'h77);
    chk("t4_retire", retire_count, 32'd7);

    // Pending writes to 7 (output register) and 12 (FIFO), both data ready
    offer(RTYPE, 5'd7, 32'h700);
    next_cycle();
    offer(RTYPE, 5'd12, 32'hC00);
    rs_q = 5'd7; rt_q = 5'd12;
    next_cycle();
    idle_in();
    chk("t5_rs_hazard", rs_hazard, !bypass_build);
    chk("t5_rt_hazard", rt_hazard, !bypass_build);
    chk("t5_rs_fwd", rs_fwd, bypass_build ? 32'h700 : 32'h0);
    chk("t5_rt_fwd", rt_fwd, bypass_build ? 32'hC00 : 32'h0);
    next_cycle();
    next_cycle();

    // Two writers of 7: the younger (FIFO) value wins over the output register
    offer(RTYPE, 5'd7, 32'h111);
    next_cycle();
    offer(RTYPE, 5'd7, 32'h222);
    next_cycle();
    idle_in();
    chk("t5b_rs_hazard", rs_hazard, !bypass_build);
    chk("t5b_rs_fwd", rs_fwd, bypass_build ? 32'h222 : 32'h0);
    next_cycle();
    next_cycle();
    chk("t5b_retire", retire_count, 32'd11);
    rs_q = '0; rt_q = '0;

    // Reset while an LW waits discards it; later load data is ignored
    offer(LW, 5'd4, 32'h40);
    next_cycle();
    idle_in();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_wr_en", wr_en, 1'b0);
    chk("t6_wr_addr", wr_addr, 5'd0);
    chk("t6_wr_data", wr_data, 32'd0);
    chk("t6_retire", retire_count, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    next_cycle();
    mem_rvalid = 1'b0;
    chk("t6_stale_load_wr_en", wr_en, 1'b0);
    chk("t6_stale_load_retire", retire_count, 32'd0);

    // Back-to-back pushes sustain one retire per cycle
    for (int i = 1; i <= 4; i++) begin
      offer(RTYPE, 5'(i), 32'h1000 + i);
      next_cycle();
      chk("t7_ready_streaming", in_ready, 1'b1);
    end
    idle_in();
    next_cycle();
    chk_write("t7_last", 5'd4, 32'h1004);
    chk("t7_retire", retire_count, 32'd4);

    // Mixed traffic, checked by the model each cycle
    for (int i = 0; i < 120; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_opcode  = ops[$urandom_range(0, 5)];
      in_dest    = 5'($urandom_range(0, 15));
      in_result  = $urandom;
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      rs_q       = 5'($urandom_range(0, 15));
      rt_q       = 5'($urandom_range(0, 15));
      next_cycle();
    end
    idle_in();
    mem_rvalid = 1'b1;
    for (int i = 0; i < 6; i++) next_cycle();
    mem_rvalid = 1'b0;
    next_cycle();
    chk("final_drained", in_ready, 1'b1);
    chk("final_exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Register-file writer for the single-issue MIPS pipeline. It takes completed-instruction results from execute/memory through a valid/ready handshake and buffers them in a small in-order FIFO. It drains them one per cycle onto the register-file write port, stalling a load at the FIFO head until its memory data returns. It also reports read-after-write hazards for the rs/rt addresses that decode is currently reading.

## Interface
Parameters:
- DEPTH, default 2: FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- reset  in  1  reset is synchronous and active-low, on the same clk.
- in_valid  in  1  a result is offered.
- in_ready  out  1  space is available; equals !full.
- in_opcode  in  6  OpCode of the completing instruction.
- in_dest  in  5  destination RegAddr: rd for RTYPE, rt for ADDI/LW, don't-care otherwise.
- in_result  in  32  ALU result.
- mem_rvalid  in  1  load data is valid this cycle.
- mem_rdata  in  32  load data.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  5  write address.
- wr_data  out  32  write data.
- rs_q, rt_q  in  5 each  addresses decode is reading this cycle.
- rs_hazard, rt_hazard  out  1 each  a pending write targets that address.
- rs_fwd, rt_fwd  out  32 each  forwarded values.
- retire_count  out  32  number of instructions retired since reset.

## Operation
- Push when in_valid && in_ready. Each entry stores the opcode, the dest, the result, a has_write flag, and a data_ok flag.
- has_write = (opcode is RTYPE, ADDI or LW) && dest != 0. BEQ, SW, J and writes to $0 retire without writing.
- data_ok is set at push for every non-LW entry. An LW entry sets data_ok when mem_rvalid is high while it is the head; its result field is then replaced with mem_rdata.
- mem_rvalid is ignored when the head is not an LW waiting for data, or when the FIFO is empty.
- Pop condition: the head is valid and data_ok is either already set or is being set this cycle. At most one pop per cycle.
- On pop, the output register loads wr_en = has_write, wr_addr = dest and wr_data = the stored result, or mem_rdata for a same-cycle load. retire_count increments by 1 and wraps at 2^32.
- When nothing pops, wr_en = 0 and wr_addr/wr_data hold their previous values.
- Push and pop can occur in the same cycle. Because in_ready = !full, a full FIFO accepts nothing, even in a cycle where it pops.
- Hazard, combinational: rs_hazard = rs_q != 0 && (any valid FIFO entry with has_write and dest == rs_q, or wr_en && wr_addr == rs_q). rt_hazard is defined the same way using rt_q.
- Without the macro: rs_fwd and rt_fwd are tied to 0.

## Timing
- Reset (reset == 0 at an edge) gives: FIFO empty, in_ready = 1, wr_en = 0, wr_addr = 0, wr_data = 0, retire_count = 0. Asserting reset while a load is pending discards it.
- Latency: a push at cycle N can pop at N+1; wr_en is then high at N+2. An LW whose mem_rvalid arrives at cycle M while it is the head gives wr_en at M+1.
- Throughput: one retire per cycle when no load is waiting.
- A waiting LW blocks all younger entries (in-order retire). in_ready drops once DEPTH entries are held.

## Configuration
- WB_BYPASS_EN defined: forwarding is enabled.
  - rs_fwd gives the value of the youngest matching source among the output register and the FIFO entries.
  - rs_hazard is cleared when that youngest match is data_ok. A waiting LW still asserts the hazard.
  - rt_fwd and rt_hazard behave the same way.
- WB_BYPASS_EN undefined: no forwarding; hazards are reported as defined under Operation.

## Structure
- The shared definitions package holds the OpCode enum (RTYPE, ADDI, BEQ, LW, SW, J), RegAddr, Register and Signal. A new packed struct WbEntry (opcode, dest, result, has_write, data_ok) is added to the package.
- One sub-module, wb_fifo: a circular DEPTH-entry buffer of WbEntry with head/tail pointers and a count. It exposes all entries for the hazard compare and has a head-update port for load data.

## Test plan
- RTYPE push, dest 5, result 0x1234 at cycle 0: wr_en high at cycle 2 with addr 5, data 0x1234; retire_count = 1.
- ADDI with dest 0: no wr_en; retire_count increments; rs_q = 0 never raises a hazard.
- LW push with dest 8 followed by ADDI push with dest 9; mem_rvalid with 0xCAFE arrives 4 cycles later: write 8 = 0xCAFE in the next cycle, then write 9 in the following cycle. The ADDI never passes the LW.
- DEPTH = 2 with a waiting LW and an ADDI queued: in_ready = 0. A push offered now is not accepted. Keep in_valid high; mem_rvalid pulses; in_ready rises the cycle after the pop.
- Pending writes to 7 and 12, rs_q = 7, rt_q = 12, with data ready:
  - WB_BYPASS_EN undefined: both hazards are 1.
  - WB_BYPASS_EN defined: hazards are 0 and fwd values are the youngest matching results.
- Drive reset low for 1 cycle while an LW is waiting: FIFO empty, wr_en = 0, retire_count = 0. A later mem_rvalid is ignored.
